conv_signal_streamer: RTL
=========================

Name: conv_signal_streamer

Overview:
- Transmit end of the conv_1d signal streaming interface.
- Buffers samples from an upstream writer in an internal FIFO, then emits one frame of frame_len samples on signal_data/signal_vld/signal_last, honouring signal_rdy backpressure.
- Sits directly in front of the 1-D convolution engine; software or a DMA front-end pushes samples in and pulses start per frame.

Parameters:
- DATA_WIDTH, 8, sample width; must match the convolution engine.
- KERNEL_SIZE, 8, convolution kernel length; used only by the optional padding feature.
- FIFO_DEPTH, 16, sample buffer entries; power of two, >= 2.
- MAX_FRAME_LEN, 1024, largest frame; LEN_WIDTH = $clog2(MAX_FRAME_LEN+1).

Ports:
- clk  input  1  clock.
- srst  input  1  synchronous active-high reset.
- in_data  input  DATA_WIDTH  sample from the upstream writer.
- in_vld  input  1  in_data valid.
- in_rdy  output  1  FIFO can accept; equals !full.
- start  input  1  single-cycle request to begin a frame; sampled only in IDLE.
- frame_len  input  LEN_WIDTH  samples in the frame; latched on an accepted start.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final beat of a frame.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- signal_data  output  DATA_WIDTH  sample to the convolution engine.
- signal_vld  output  1  signal_data valid.
- signal_last  output  1  marks the final beat of the frame.
- signal_rdy  input  1  downstream accepts the beat.

Behaviour:
- Reset (srst high at a clk edge):
  - state=IDLE; FIFO emptied.
  - in_rdy=1 after reset deasserts; fifo_count=0.
  - busy=0, done=0; signal_vld=0, signal_last=0, signal_data=0.
  - Reset mid-frame discards the frame and any buffered samples; no done pulse.
- Input side:
  - A push occurs when in_vld && in_rdy at a clk edge.
  - Pushes are accepted in every state, so samples may be preloaded before start.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - When full, in_rdy=0 and the input is ignored. No overflow is possible.
- Output register:
  - signal_data/vld/last are registered.
  - A beat is handshaken when signal_vld && signal_rdy.
  - Once signal_vld is asserted, signal_vld, signal_data and signal_last hold stable until the handshake.
  - The register loads when (!signal_vld || signal_rdy) and a source beat is available.
- Latency:
  - Sample pushed at edge t into an empty FIFO while in STREAM appears on signal_vld after edge t+1.
  - Sustained throughput is 1 beat/cycle when signal_rdy=1 and the FIFO is non-empty.
- FSM:
  - IDLE:
    - start && frame_len!=0 → latch remaining=frame_len, go to STREAM.
    - start with frame_len==0 → ignored, stay IDLE.
    - frame_len > MAX_FRAME_LEN → saturate to MAX_FRAME_LEN.
  - STREAM:
    - Pop the FIFO into the output register when it is loadable and the FIFO is non-empty.
    - remaining decrements on each pop.
    - The beat popped when remaining==1 carries signal_last=1, then go to DRAIN.
    - FIFO empty → signal_vld drops after the current beat is accepted (bubble); no timeout.
  - DRAIN:
    - Wait for the last beat's handshake.
    - Then pulse done for one cycle, go to IDLE, busy=0 in the same cycle as done.
- start while busy is ignored; a new start is accepted in IDLE on the cycle after done.
- Samples beyond frame_len stay in the FIFO for the next frame.

Optional Feature:
- Macro CONV_SIGNAL_STREAMER_PAD_EN.
- Defined:
  - After the final real sample, enter state PAD and emit KERNEL_SIZE-1 zero-valued beats, one per loadable cycle with no FIFO dependency.
  - signal_last is on the last zero beat, not the last real sample.
  - PAD → DRAIN.
  - The frame is KERNEL_SIZE-1+frame_len beats.
- Undefined: no PAD state; behaviour exactly as above.

Test Plan:
- Reset, then preload 4 samples 0x01..0x04, then start with frame_len=4 and signal_rdy=1:
  - Beats 01,02,03,04 on consecutive cycles; signal_last only on 04.
  - done pulses once; fifo_count returns to 0.
- signal_rdy toggling 1,0,0,1,... during an 8-sample frame:
  - signal_data and signal_last stay stable while stalled; no beat lost or duplicated.
- Fill the FIFO to FIFO_DEPTH=16 without start:
  - in_rdy=0 and fifo_count=16; the 17th push is ignored.
  - After start with frame_len=16, all 16 beats emit in order.
- start with frame_len=0, then start while busy:
  - Both ignored; busy stays as-is; no done pulse.
- Frame of 6 with the FIFO empty at start, samples pushed one per 3 cycles:
  - signal_vld gaps appear; signal_last is on the 6th beat; extra pushed samples remain in the FIFO.
- srst asserted mid-frame after 2 of 5 beats:
  - All outputs return to reset values the next cycle; FIFO is empty; no done pulse.
  - With PAD_EN and KERNEL_SIZE=8, frame_len=3 gives 3 data beats plus 7 zero beats, signal_last on the 10th beat.

Source files
------------

// File: rtl/conv_signal_streamer.sv
// Transmit end of the conv_1d signal stream: FIFO-buffered samples emitted as frames with valid/ready backpressure.
// Optional zero padding of KERNEL_SIZE-1 trailing beats is enabled by defining CONV_SIGNAL_STREAMER_PAD_EN.
module conv_signal_streamer #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned KERNEL_SIZE   = 8,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned MAX_FRAME_LEN = 1024
) (
    input  logic                                 clk,
    input  logic                                 srst,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic                                 in_vld,
    output logic                                 in_rdy,
    input  logic                                 start,
    input  logic [$clog2(MAX_FRAME_LEN+1)-1:0]   frame_len,
    output logic                                 busy,
    output logic                                 done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
    output logic [DATA_WIDTH-1:0]                signal_data,
    output logic                                 signal_vld,
    output logic                                 signal_last,
    input  logic                                 signal_rdy
);
    localparam int unsigned LEN_WIDTH = $clog2(MAX_FRAME_LEN + 1);
    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);

    // Elaboration-time sanity check of the configuration
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || KERNEL_SIZE < 1) begin : g_bad_cfg
        $error("conv_signal_streamer: FIFO_DEPTH must be a power of two >= 2 and KERNEL_SIZE >= 1");
    end

`ifdef CONV_SIGNAL_STREAMER_PAD_EN
    localparam int unsigned PAD_BEATS = KERNEL_SIZE - 1;
    localparam int unsigned PAD_WIDTH = $clog2(KERNEL_SIZE + 1);
    typedef enum logic [1:0] {IDLE, STREAM, PAD, DRAIN} state_t;
    logic [PAD_WIDTH-1:0] pad_cnt;
`else
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
`endif

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  push;
    logic                  pop;
    logic                  load_ok;
    logic                  fifo_empty;

    assign in_rdy     = (fifo_count != CNT_WIDTH'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign load_ok    = !signal_vld || signal_rdy;
    assign push       = in_vld && in_rdy;
    assign pop        = (state == STREAM) && load_ok && !fifo_empty;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers, frame FSM and the registered output beat
    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            remaining   <= '0;
            done        <= 1'b0;
            signal_data <= '0;
            signal_vld  <= 1'b0;
            signal_last <= 1'b0;
`ifdef CONV_SIGNAL_STREAMER_PAD_EN
            pad_cnt     <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_WIDTH'(1);
                2'b01:   fifo_count <= fifo_count - CNT_WIDTH'(1);
                default: fifo_count <= fifo_count;
            endcase

            // An accepted beat empties the register unless a new beat is loaded below
            if (signal_vld && signal_rdy) begin
                signal_vld  <= 1'b0;
                signal_last <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start && frame_len != '0) begin
                        remaining <= (frame_len > LEN_WIDTH'(MAX_FRAME_LEN)) ?
                                     LEN_WIDTH'(MAX_FRAME_LEN) : frame_len;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (pop) begin
                        signal_data <= mem[rd_ptr];
                        signal_vld  <= 1'b1;
                        remaining   <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
`ifdef CONV_SIGNAL_STREAMER_PAD_EN
                            if (PAD_BEATS == 0) begin
                                signal_last <= 1'b1;
                                state       <= DRAIN;
                            end else begin
                                signal_last <= 1'b0;
                                pad_cnt     <= PAD_WIDTH'(PAD_BEATS);
                                state       <= PAD;
                            end
`else
                            signal_last <= 1'b1;
                            state       <= DRAIN;
`endif
                        end else begin
                            signal_last <= 1'b0;
                        end
                    end
                end
`ifdef CONV_SIGNAL_STREAMER_PAD_EN
                PAD: begin
                    if (load_ok) begin
                        signal_data <= '0;
                        signal_vld  <= 1'b1;
                        pad_cnt     <= pad_cnt - PAD_WIDTH'(1);
                        signal_last <= (pad_cnt == PAD_WIDTH'(1));
                        if (pad_cnt == PAD_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
`endif
                DRAIN: begin
                    if (signal_vld && signal_rdy) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
